vliw_id_ex_pipe: RTL
====================

VLIW_ID_EX_PIPE -- requirements
Module: vliw_id_ex_pipe

Interface
REQ-001 Parameter LANES, default 4: number of VLIW issue lanes carried by the stage.
REQ-002 Parameter WIDTH, default 64: decoded-payload bits per lane.
REQ-003 Parameter CNT_W, default 16: width of each statistics counter.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 flush  in  1  discard all held and incoming bundles this cycle.
REQ-007 in_valid  in  1  upstream bundle present.
REQ-008 in_ready  out  1  stage can accept a bundle; registered.
REQ-009 in_nop  in  LANES  per-lane NOP mask; bit i refers to lane i.
REQ-010 in_pc  in  32  bundle PC.
REQ-011 in_data  in  LANES*WIDTH  lane payloads; lane i occupies bits [i*WIDTH +: WIDTH].
REQ-012 out_valid  out  1  bundle presented downstream.
REQ-013 out_ready  in  1  downstream accepts the presented bundle.
REQ-014 out_nop  out  LANES; out_pc  out  32; out_data  out  LANES*WIDTH: presented bundle fields.
REQ-015 stall_cnt  out  CNT_W  cycles in which out_valid=1 and out_ready=0.
REQ-016 bubble_cnt  out  CNT_W  cycles in which out_valid=0.

Function
REQ-017 Storage SHALL be two entries: main, which drives the out_* ports, and skid; each entry holds its own valid bit.
REQ-018 In-accept SHALL occur when in_valid=1 and in_ready=1; out-accept SHALL occur when out_valid=1 and out_ready=1.
REQ-019 in_ready SHALL equal the complement of skid valid, registered, with no combinational path from out_ready.
REQ-020 Latency: a bundle accepted into an empty stage SHALL appear on out_* in the next cycle.
REQ-021 Main empty, or main out-accepted, with skid empty: an in-accepted bundle SHALL load main.
REQ-022 Main full and not out-accepted: an in-accepted bundle SHALL load skid, and in_ready SHALL drop the next cycle.
REQ-023 Skid full and main out-accepted: main SHALL take the skid contents, skid SHALL clear, and in_ready SHALL rise the next cycle.
REQ-024 Bundle order SHALL be preserved; a bundle SHALL never be lost or duplicated.
REQ-025 When main empties without a refill, out_valid SHALL be 0, out_nop SHALL be all ones, and out_pc/out_data SHALL hold their last values.
REQ-026 flush SHALL take priority over every transfer: both valids clear, out_nop is all ones, any in-accept that cycle is discarded, and in_ready=1 the next cycle.
REQ-027 A bundle with in_nop all ones SHALL still occupy an entry and follow the handshake; no bundle is dropped on NOP content.
REQ-028 Under simultaneous out-accept and in-accept with skid empty, main SHALL update in place and throughput SHALL be one bundle per cycle.

Reset
REQ-029 While rst=1 the stage SHALL hold: out_valid=0, out_nop all ones, out_pc=0, out_data=0, skid empty, in_ready=1, stall_cnt=0, bubble_cnt=0.
REQ-030 rst SHALL override flush and all handshakes; in-flight bundles at reset SHALL be discarded.

Configuration
REQ-031 Macro VLIW_PIPE_STAT_EN defined: stall_cnt and bubble_cnt SHALL count as REQ-015/016, saturate at all ones, clear only on rst, and ignore flush.
REQ-032 Macro VLIW_PIPE_STAT_EN undefined: both counter ports SHALL still exist, tied to constant 0, with no counter flops instantiated.

Verification
REQ-033 LANES=4, WIDTH=64: rst, then one bundle with pc=0x100, nop=4'b0010 -> next cycle out_valid=1, out_pc=0x100, out_nop=4'b0010.
REQ-034 Stream pcs 0x0,0x4,0x8 with out_ready=1 -> outputs appear in order on consecutive cycles; in_ready stays 1.
REQ-035 Stream with out_ready=0 -> second bundle enters skid, in_ready=0 from the next cycle; raise out_ready -> order 0x0,0x4 preserved; in_ready returns to 1 one cycle after skid drains.
REQ-036 Both entries full, then flush=1 with in_valid=1 -> next cycle out_valid=0, out_nop=4'hF, in_ready=1; the incoming bundle never appears.
REQ-037 VLIW_PIPE_STAT_EN defined, CNT_W=4, out_valid=1 with out_ready=0 held for 20 cycles -> stall_cnt=15 (saturated); then rst -> stall_cnt=0.
REQ-038 VLIW_PIPE_STAT_EN undefined, same stimulus as REQ-037 -> stall_cnt=0 and bubble_cnt=0 throughout.

Source files
------------

// File: rtl/vliw_id_ex_pipe.sv
// VLIW ID/EX pipeline stage: a two-entry (main + skid) elastic buffer that
// carries one issue bundle (per-lane NOP mask, PC, lane payloads) per cycle.
// in_ready is taken straight from a flop, so there is no combinational path
// from out_ready back to the upstream stage.
// Optional feature: define VLIW_PIPE_STAT_EN to build the saturating stall and
// bubble counters; otherwise both counter ports are tied to zero.
module vliw_id_ex_pipe #(
    parameter int LANES = 4,
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES-1:0]       in_nop,
    input  logic [31:0]            in_pc,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES-1:0]       out_nop,
    output logic [31:0]            out_pc,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       bubble_cnt
);

    logic                   mainValid_q, mainValid_d;
    logic [LANES-1:0]       mainNop_q, mainNop_d;
    logic [31:0]            mainPc_q, mainPc_d;
    logic [LANES*WIDTH-1:0] mainData_q, mainData_d;

    logic                   skidValid_q, skidValid_d;
    logic [LANES-1:0]       skidNop_q, skidNop_d;
    logic [31:0]            skidPc_q, skidPc_d;
    logic [LANES*WIDTH-1:0] skidData_q, skidData_d;

    logic inAccept;
    logic outAccept;

    assign in_ready  = ~skidValid_q;
    assign inAccept  = in_valid & in_ready;
    assign outAccept = mainValid_q & out_ready;

    // An empty main entry presents an all-NOP bundle; PC and payload keep their last values.
    assign out_valid = mainValid_q;
    assign out_nop   = mainValid_q ? mainNop_q : {LANES{1'b1}};
    assign out_pc    = mainPc_q;
    assign out_data  = mainData_q;

    // Next-state of both entries: flush wins, then skid refills main, then a new bundle fills main or skid.
    always_comb begin
        mainValid_d = mainValid_q;
        mainNop_d   = mainNop_q;
        mainPc_d    = mainPc_q;
        mainData_d  = mainData_q;
        skidValid_d = skidValid_q;
        skidNop_d   = skidNop_q;
        skidPc_d    = skidPc_q;
        skidData_d  = skidData_q;

        if (flush) begin
            mainValid_d = 1'b0;
            skidValid_d = 1'b0;
        end else if (!mainValid_q || outAccept) begin
            if (skidValid_q) begin
                mainValid_d = 1'b1;
                mainNop_d   = skidNop_q;
                mainPc_d    = skidPc_q;
                mainData_d  = skidData_q;
                skidValid_d = 1'b0;
            end else if (inAccept) begin
                mainValid_d = 1'b1;
                mainNop_d   = in_nop;
                mainPc_d    = in_pc;
                mainData_d  = in_data;
            end else begin
                mainValid_d = 1'b0;
            end
        end else if (inAccept) begin
            skidValid_d = 1'b1;
            skidNop_d   = in_nop;
            skidPc_d    = in_pc;
            skidData_d  = in_data;
        end
    end

    // Entry registers with synchronous reset that discards anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            mainValid_q <= 1'b0;
            mainNop_q   <= {LANES{1'b1}};
            mainPc_q    <= 32'd0;
            mainData_q  <= '0;
            skidValid_q <= 1'b0;
            skidNop_q   <= {LANES{1'b1}};
            skidPc_q    <= 32'd0;
            skidData_q  <= '0;
        end else begin
            mainValid_q <= mainValid_d;
            mainNop_q   <= mainNop_d;
            mainPc_q    <= mainPc_d;
            mainData_q  <= mainData_d;
            skidValid_q <= skidValid_d;
            skidNop_q   <= skidNop_d;
            skidPc_q    <= skidPc_d;
            skidData_q  <= skidData_d;
        end
    end

`ifdef VLIW_PIPE_STAT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0] bubbleCnt_q, bubbleCnt_d;

    // Saturating counters of stalled and empty output cycles; flush does not touch them.
    always_comb begin
        stallCnt_d  = stallCnt_q;
        bubbleCnt_d = bubbleCnt_q;
        if (mainValid_q && !out_ready && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + CNT_ONE;
        end
        if (!mainValid_q && (bubbleCnt_q != {CNT_W{1'b1}})) begin
            bubbleCnt_d = bubbleCnt_q + CNT_ONE;
        end
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt_q  <= '0;
            bubbleCnt_q <= '0;
        end else begin
            stallCnt_q  <= stallCnt_d;
            bubbleCnt_q <= bubbleCnt_d;
        end
    end

    assign stall_cnt  = stallCnt_q;
    assign bubble_cnt = bubbleCnt_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule
